data_sram_responder: RTL

- Synchronous word-organised data RAM that sits on the far side of the pipeline's data SRAM interface and services the en/wen/addr/wdata requests issued by the execute stage.
- Returns read data to the memory stage after a configurable latency.
- Supports per-byte writes with read-first semantics.
- Flags out-of-window addresses and latches the first faulting address for debug.

---
 rtl/data_sram_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Word-organised data RAM behind the pipeline's data SRAM port: read-first byte writes,
// a fixed-latency in-order response pipeline, and sticky out-of-window fault capture.
module data_sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    input  logic        err_clr,
    output logic        addr_err,
    output logic [31:0] err_addr
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned TAG_LSB = ADDR_W + 2;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("data_sram_responder: LATENCY must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("data_sram_responder: ADDR_W must be in 1..29");
    end

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              in_window;
    logic              accept;
    logic              fault;
    logic [31:0]       resp_word;
    logic              unused_addr_bits;

    assign word_idx         = data_sram_addr[ADDR_W+1:2];
    assign in_window        = (data_sram_addr[31:TAG_LSB] == BASE[31:TAG_LSB]);
    assign accept           = data_sram_en && !reset;
    assign fault            = accept && !in_window;
    // Faulting accesses still respond on schedule, but with zero data.
    assign resp_word        = in_window ? mem[word_idx] : 32'h0000_0000;
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // Array write; the response above samples the pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (accept && in_window) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    logic [LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [31:0]        pipe_data_q [LATENCY];
    logic [31:0]        pipe_data_d [LATENCY];

    // Data in each stage only moves with a valid token, so the last stage holds rdata.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_data_d     = pipe_data_q;
        pipe_valid_d[0] = accept;
        if (accept) begin
            pipe_data_d[0] = resp_word;
        end
        for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            if (pipe_valid_q[k-1]) begin
                pipe_data_d[k] = pipe_data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
        end
    end

    assign data_sram_rvalid = pipe_valid_q[LATENCY-1];
    assign data_sram_rdata  = pipe_data_q[LATENCY-1];

    logic        addr_err_q, addr_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // A new fault beats a simultaneous clear; only the first fault since clear is captured.
    always_comb begin
        addr_err_d = addr_err_q;
        err_addr_d = err_addr_q;
        if (fault) begin
            addr_err_d = 1'b1;
            if (!addr_err_q || err_clr) begin
                err_addr_d = data_sram_addr;
            end
        end else if (err_clr) begin
            addr_err_d = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            addr_err_q <= addr_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign addr_err = addr_err_q;
    assign err_addr = err_addr_q;

endmodule
